// File: rtl/pic_pkg.sv
// Shared definitions for the 8259 PIC bus front end: init-sequence states,
// command-word bit positions and the strobe bundle issued to the control core.
package pic_pkg;

    typedef enum logic [2:0] {
        ST_UNINIT = 3'd0,
        ST_ICW2   = 3'd1,
        ST_ICW3   = 3'd2,
        ST_ICW4   = 3'd3,
        ST_READY  = 3'd4
    } pic_init_state_t;

    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int CW_D3     = 3;
    localparam int CW_D4     = 4;

    typedef struct packed {
        logic ocw3;
        logic ocw2;
        logic ocw1;
        logic icw4;
        logic icw3;
        logic icw2;
        logic icw1;
    } pic_strobes_t;

endpackage

// File: rtl/pic_sync_edge.sv
// Multi-flop synchroniser for an asynchronous level, plus a one-cycle pulse
// on its synchronised rising edge.
module pic_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic level,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge value of its neighbour; blocking here would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], async_in};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign level = sync_q[SYNC_STAGES-1];
    assign rise  = level & ~prev_q;

endmodule

// File: rtl/pic_bus_sequencer.sv
// 8259 host bus front end: synchronises host strobes, captures write data,
// walks the ICW1..ICW4 init sequence and issues one-cycle ICW/OCW strobes.
module pic_bus_sequencer
    import pic_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cs_n,
    input  logic                  rd_n,
    input  logic                  wr_n,
    input  logic                  a0,
    inout  wire [DATA_WIDTH-1:0]  data_bus,
    input  logic [DATA_WIDTH-1:0] read_data,
    output logic [DATA_WIDTH-1:0] internal_data_bus,
    output logic                  icw1,
    output logic                  icw2,
    output logic                  icw3,
    output logic                  icw4,
    output logic                  ocw1,
    output logic                  ocw2,
    output logic                  ocw3,
    output logic                  sngl,
    output logic                  ic4,
    output logic                  init_done,
    output logic                  rd_pulse,
    output logic                  rd_active
);

    logic wr_act, rd_act;
    logic wr_level, wr_rise;
    logic rd_level, rd_rise;
    logic drive_bus;

    assign wr_act = ~cs_n & ~wr_n;
    assign rd_act = ~cs_n & ~rd_n;

    pic_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_wr_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (wr_act),
        .level    (wr_level),
        .rise     (wr_rise)
    );

    pic_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_rd_sync (
        .clk      (clk),
        .rst_n    (rst_n),
        .async_in (rd_act),
        .level    (rd_level),
        .rise     (rd_rise)
    );

    // Read-back is driven straight from the raw pins so the host sees data within its own access.
    assign drive_bus = rst_n & rd_act & ~wr_act;
    assign data_bus  = drive_bus ? read_data : {DATA_WIDTH{1'bz}};

    logic a0_q;
    logic cap_pending;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            internal_data_bus <= '0;
            a0_q              <= 1'b0;
            cap_pending       <= 1'b0;
        end else begin
            cap_pending <= wr_rise;
            if (wr_rise) begin
                internal_data_bus <= data_bus;
                a0_q              <= a0;
            end
        end
    end

    pic_init_state_t state_q, state_d;
    pic_strobes_t    strb_q, strb_d;
    logic            sngl_d, ic4_d;
    logic            cw_d4, cw_d3;

    assign cw_d4 = internal_data_bus[CW_D4];
    assign cw_d3 = internal_data_bus[CW_D3];

    // NOTE: every always_comb output gets a default before any branch; a path
    // that leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        strb_d  = '0;
        sngl_d  = sngl;
        ic4_d   = ic4;
        if (cap_pending) begin
            if (!a0_q && cw_d4) begin
                strb_d.icw1 = 1'b1;
                sngl_d      = internal_data_bus[ICW1_SNGL];
                ic4_d       = internal_data_bus[ICW1_IC4];
                state_d     = ST_ICW2;
            end else begin
                case (state_q)
                    ST_ICW2: if (a0_q) begin
                        strb_d.icw2 = 1'b1;
                        if (!sngl)    state_d = ST_ICW3;
                        else if (ic4) state_d = ST_ICW4;
                        else          state_d = ST_READY;
                    end
                    ST_ICW3: if (a0_q) begin
                        strb_d.icw3 = 1'b1;
                        state_d     = ic4 ? ST_ICW4 : ST_READY;
                    end
                    ST_ICW4: if (a0_q) begin
                        strb_d.icw4 = 1'b1;
                        state_d     = ST_READY;
                    end
                    ST_READY: begin
                        if (a0_q)        strb_d.ocw1 = 1'b1;
                        else if (!cw_d3) strb_d.ocw2 = 1'b1;
                        else             strb_d.ocw3 = 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_UNINIT;
            strb_q    <= '0;
            sngl      <= 1'b0;
            ic4       <= 1'b0;
            rd_pulse  <= 1'b0;
            rd_active <= 1'b0;
        end else begin
            state_q   <= state_d;
            strb_q    <= strb_d;
            sngl      <= sngl_d;
            ic4       <= ic4_d;
            rd_pulse  <= rd_rise & ~wr_level;
            rd_active <= rd_level & ~wr_level;
        end
    end

    assign icw1      = strb_q.icw1;
    assign icw2      = strb_q.icw2;
    assign icw3      = strb_q.icw3;
    assign icw4      = strb_q.icw4;
    assign ocw1      = strb_q.ocw1;
    assign ocw2      = strb_q.ocw2;
    assign ocw3      = strb_q.ocw3;
    assign init_done = (state_q == ST_READY);

endmodule

// File: tb/tb_pic_bus_sequencer.sv
// Directed + randomized bench for pic_bus_sequencer against a queue-based model
// of the ICW/OCW command protocol.
module tb_pic_bus_sequencer;

    localparam int DW  = 8;
    localparam int SS  = 2;
    localparam int LAT = SS + 2;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, a0 = 1'b0;
    logic [DW-1:0] read_data = '0;
    logic [DW-1:0] tb_data = '0;
    logic          tb_en = 1'b0;
    wire  [DW-1:0] data_bus;
    logic [DW-1:0] internal_data_bus;
    logic          icw1, icw2, icw3, icw4, ocw1, ocw2, ocw3;
    logic          sngl, ic4, init_done, rd_pulse, rd_active;

    assign data_bus = tb_en ? tb_data : {DW{1'bz}};

    pic_bus_sequencer #(.DATA_WIDTH(DW), .SYNC_STAGES(SS)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .cs_n              (cs_n),
        .rd_n              (rd_n),
        .wr_n              (wr_n),
        .a0                (a0),
        .data_bus          (data_bus),
        .read_data         (read_data),
        .internal_data_bus (internal_data_bus),
        .icw1              (icw1),
        .icw2              (icw2),
        .icw3              (icw3),
        .icw4              (icw4),
        .ocw1              (ocw1),
        .ocw2              (ocw2),
        .ocw3              (ocw3),
        .sngl              (sngl),
        .ic4               (ic4),
        .init_done         (init_done),
        .rd_pulse          (rd_pulse),
        .rd_active         (rd_active)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Protocol model: ICW1 loads the list of command words still owed;
    // strobe index 0..3 = icw1..icw4, 4..6 = ocw1..ocw3, -1 = no strobe.
    int exp_q[$];
    bit m_ready = 1'b0;
    bit m_sngl  = 1'b0;
    bit m_ic4   = 1'b0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        exp_q.delete();
        m_ready = 1'b0;
        m_sngl  = 1'b0;
        m_ic4   = 1'b0;
    endfunction

    function automatic int model_write(input bit a0v, input logic [7:0] d);
        int idx = -1;
        if (!a0v && d[4]) begin
            idx     = 0;
            m_sngl  = d[1];
            m_ic4   = d[0];
            m_ready = 1'b0;
            exp_q.delete();
            exp_q.push_back(1);
            if (!m_sngl) exp_q.push_back(2);
            if (m_ic4)   exp_q.push_back(3);
        end else if (exp_q.size() != 0) begin
            if (a0v) begin
                idx = exp_q.pop_front();
                if (exp_q.size() == 0) m_ready = 1'b1;
            end
        end else if (m_ready) begin
            if (a0v)       idx = 4;
            else if (d[3]) idx = 6;
            else           idx = 5;
        end
        return idx;
    endfunction

    task automatic do_write(input bit a0v, input logic [7:0] d, input int hold,
                            input bit with_rd, input string tag);
        int         cnt[7];
        int         first = -1;
        int         idx;
        int         total = 0;
        int         multi = 0;
        int         rd_seen = 0;
        logic [6:0] s;
        for (int j = 0; j < 7; j++) cnt[j] = 0;
        idx = model_write(a0v, d);
        @(negedge clk);
        a0      = a0v;
        tb_data = d;
        tb_en   = 1'b1;
        cs_n    = 1'b0;
        wr_n    = 1'b0;
        if (with_rd) begin
            rd_n = 1'b0;
            #1;
            check({tag, "/bus_not_driven"}, {24'h0, data_bus}, {24'h0, d});
        end
        for (int k = 1; k <= hold + 6; k++) begin
            @(negedge clk);
            s = {ocw3, ocw2, ocw1, icw4, icw3, icw2, icw1};
            for (int j = 0; j < 7; j++) if (s[j]) cnt[j]++;
            if (s != 0 && first < 0) first = k;
            if ($countones(s) > 1) multi++;
            if (rd_pulse || rd_active) rd_seen++;
            if (k == hold) begin
                cs_n  = 1'b1;
                wr_n  = 1'b1;
                rd_n  = 1'b1;
                tb_en = 1'b0;
            end
        end
        for (int j = 0; j < 7; j++) total += cnt[j];
        check({tag, "/strobe_total"}, total, (idx >= 0) ? 1 : 0);
        if (idx >= 0) begin
            check({tag, "/strobe_which"}, cnt[idx], 1);
            check({tag, "/strobe_latency"}, first, LAT);
        end
        check({tag, "/one_hot"}, multi, 0);
        if (with_rd) check({tag, "/rd_suppressed"}, rd_seen, 0);
        check({tag, "/capture"}, {24'h0, internal_data_bus}, {24'h0, d});
        check({tag, "/sngl"}, {31'h0, sngl}, {31'h0, m_sngl});
        check({tag, "/ic4"}, {31'h0, ic4}, {31'h0, m_ic4});
        check({tag, "/init_done"}, {31'h0, init_done}, {31'h0, m_ready});
    endtask

    task automatic do_read(input logic [7:0] rv, input int hold);
        int pulses = 0;
        int first  = -1;
        read_data = rv;
        @(negedge clk);
        cs_n = 1'b0;
        rd_n = 1'b0;
        #1;
        check("read/bus_driven", {24'h0, data_bus}, {24'h0, rv});
        for (int k = 1; k <= hold + 4; k++) begin
            @(negedge clk);
            if (rd_pulse) begin
                pulses++;
                if (first < 0) first = k;
            end
            if (k == SS + 1) check("read/rd_active", {31'h0, rd_active}, 32'h1);
            if (k == hold) begin
                cs_n = 1'b1;
                rd_n = 1'b1;
                #1;
                check("read/bus_released", {24'h0, data_bus}, {24'h0, 8'hzz});
            end
        end
        check("read/rd_pulse_count", pulses, 1);
        check("read/rd_pulse_latency", first, SS + 1);
        check("read/rd_active_end", {31'h0, rd_active}, 32'h0);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "/strobes"}, {25'h0, ocw3, ocw2, ocw1, icw4, icw3, icw2, icw1}, 32'h0);
        check({tag, "/idb"}, {24'h0, internal_data_bus}, 32'h0);
        check({tag, "/flags"}, {27'h0, sngl, ic4, init_done, rd_pulse, rd_active}, 32'h0);
        check({tag, "/bus_z"}, {24'h0, data_bus}, {24'h0, 8'hzz});
    endtask

    initial begin
        // Reset asserted from time 0; sample mid-clock.
        #3;
        check_reset_state("reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();

        // Writes before any ICW1 are ignored.
        do_write(1'b1, 8'h55, 4, 1'b0, "uninit_a0_1");
        do_write(1'b0, 8'h0A, 4, 1'b0, "uninit_a0_0");

        // Single, ICW4 needed: no ICW3.
        do_write(1'b0, 8'h13, 4, 1'b0, "t2_icw1");
        do_write(1'b1, 8'h20, 4, 1'b0, "t2_icw2");
        do_write(1'b1, 8'h01, 5, 1'b0, "t2_icw4");

        // Cascade without ICW4, restarted by ICW1 while waiting for ICW3.
        do_write(1'b0, 8'h10, 4, 1'b0, "t3_icw1");
        do_write(1'b1, 8'h08, 4, 1'b0, "t3_icw2");
        do_write(1'b0, 8'h10, 4, 1'b0, "t4_icw1_restart");
        do_write(1'b0, 8'h06, 4, 1'b0, "t4_ignored_in_icw2");
        do_write(1'b1, 8'h08, 4, 1'b0, "t3_icw2b");
        do_write(1'b1, 8'h04, 4, 1'b0, "t3_icw3");
        do_write(1'b1, 8'hFF, 4, 1'b0, "t3_ocw1");
        do_write(1'b0, 8'h20, 4, 1'b0, "t3_ocw2");
        do_write(1'b0, 8'h0B, 4, 1'b0, "t3_ocw3");

        // Reads, then read colliding with a write.
        do_read(8'hA5, 5);
        read_data = 8'h5A;
        do_write(1'b0, 8'h0B, 5, 1'b1, "t5_rd_wr");

        // Long write pulse.
        do_write(1'b1, 8'hC3, 20, 1'b0, "t6_long");

        // Reset while waiting for ICW2.
        do_write(1'b0, 8'h13, 4, 1'b0, "t6_icw1");
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_state("t6_reset");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        do_write(1'b1, 8'h20, 4, 1'b0, "t6_after_reset");

        // Random command stream.
        for (int i = 0; i < 40; i++) begin
            logic       ra0;
            logic [7:0] rd8;
            int         rh;
            ra0 = 1'($urandom_range(0, 1));
            rd8 = 8'($urandom);
            rh  = 4 + $urandom_range(0, 4);
            do_write(ra0, rd8, rh, 1'b0, $sformatf("rand%0d", i));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
